// File: rtl/lab_pc_pkg.sv
// lab_pc_pkg: shared FSM states, 7-segment table and popcount for the lab PC allocator
package lab_pc_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int MAX_PCS = 9;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  function automatic logic [3:0] popcount(input logic [MAX_PCS-1:0] m);
    popcount = '0;
    for (int i = 0; i < MAX_PCS; i++) popcount = popcount + {3'b000, m[i]};
  endfunction
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    return (v < 4'd10) ? SEG_TAB[v] : SEG_DASH;
  endfunction
endpackage

// File: rtl/lab_pc_alloc_ctrl_rr_pick.sv
// lab_pc_rr_pick: first free machine scanning upward from ptr+1 with wrap
module lab_pc_rr_pick #(
  parameter int N_PCS = 5,
  parameter int ID_W = 3
) (
  input  logic [N_PCS-1:0] busy,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  id
);
  int j;
  always_comb begin
    found = 1'b0;
    id = '0;
    j = 0;
    // descending offset so the nearest free index is written last and wins
    for (int k = N_PCS; k >= 1; k--) begin
      j = (int'(ptr) + k) % N_PCS;
      if (!busy[j]) begin
        found = 1'b1;
        id = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/lab_pc_alloc_ctrl.sv
// lab_pc_alloc_ctrl: round-robin lab PC allocator with occupancy mask and free-count display
// Optional session auto-release with LAB_PC_TIMEOUT_EN.
module lab_pc_alloc_ctrl
  import lab_pc_pkg::*;
#(
  parameter int N_PCS = 5,
  parameter int ID_W = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  input  logic             rel_valid,
  input  logic [ID_W-1:0]  rel_id,
  output logic             rel_err,
  output logic [N_PCS-1:0] busy,
  output logic [3:0]       free_count,
  output logic             full,
  output logic [6:0]       seg
`ifdef LAB_PC_TIMEOUT_EN
  ,
  output logic             timeout_valid,
  output logic [ID_W-1:0]  timeout_id
`endif
);
  if (N_PCS < 1 || N_PCS > MAX_PCS || (1 << ID_W) < N_PCS || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("lab_pc_alloc_ctrl: illegal parameters");
  end
  state_t state_q, state_d;
  logic [N_PCS-1:0] busy_q, busy_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, pick_id;
  logic rel_err_q, rel_err_d, full_q, full_d, pick_found, accept, rel_ok;
  logic [3:0] free_count_q, free_count_d;
  logic [6:0] seg_q, seg_d;
  lab_pc_rr_pick #(.N_PCS(N_PCS), .ID_W(ID_W)) u_pick (
    .busy(busy_q), .ptr(ptr_q), .found(pick_found), .id(pick_id)
  );
  assign req_ready = (state_q == IDLE) && !full_q;
  assign accept = req_ready && req_valid && pick_found;
  // the machine in its GRANT cycle is already marked busy, so it is excluded explicitly
  assign rel_ok = rel_valid && (int'(rel_id) < N_PCS) && busy_q[rel_id]
                  && !((state_q == GRANT) && (rel_id == id_q));
`ifdef LAB_PC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q [N_PCS];
  logic [CW-1:0] cnt_d [N_PCS];
  logic to_fire, to_valid_q, to_valid_d;
  logic [ID_W-1:0] to_id, to_id_q, to_id_d;
  always_comb begin
    to_fire = 1'b0;
    to_id = '0;
    for (int i = N_PCS - 1; i >= 0; i--) begin
      if (busy_q[i] && cnt_q[i] == CW'(TIMEOUT_CYCLES - 1)) begin
        to_fire = 1'b1;
        to_id = ID_W'(i);
      end
    end
    // expired counters hold at the limit until their machine gets its turn
    for (int i = 0; i < N_PCS; i++)
      cnt_d[i] = (accept && pick_id == ID_W'(i)) ? '0 :
                 (busy_q[i] && cnt_q[i] != CW'(TIMEOUT_CYCLES - 1)) ? cnt_q[i] + 1'b1 : cnt_q[i];
    to_valid_d = to_fire;
    to_id_d = to_fire ? to_id : to_id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      to_valid_q <= 1'b0;
      to_id_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      to_valid_q <= to_valid_d;
      to_id_q <= to_id_d;
    end
  end
  assign timeout_valid = to_valid_q;
  assign timeout_id = to_id_q;
`endif
  always_comb begin
    busy_d = busy_q;
    ptr_d = ptr_q;
    id_d = id_q;
    rel_err_d = rel_valid && !rel_ok;
    if (rel_ok) busy_d[rel_id] = 1'b0;
`ifdef LAB_PC_TIMEOUT_EN
    if (to_fire) busy_d[to_id] = 1'b0;
`endif
    if (accept) begin
      busy_d[pick_id] = 1'b1;
      ptr_d = pick_id;
      id_d = pick_id;
    end
    state_d = accept ? GRANT : IDLE;
    free_count_d = 4'(N_PCS) - popcount(MAX_PCS'(busy_d));
    full_d = free_count_d == 4'd0;
    seg_d = seg_of(free_count_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= '0;
      ptr_q <= ID_W'(N_PCS - 1);
      id_q <= '0;
      rel_err_q <= 1'b0;
      free_count_q <= 4'(N_PCS);
      full_q <= 1'b0;
      seg_q <= seg_of(4'(N_PCS));
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      rel_err_q <= rel_err_d;
      free_count_q <= free_count_d;
      full_q <= full_d;
      seg_q <= seg_d;
    end
  end
  assign grant_valid = state_q == GRANT;
  assign grant_id = id_q;
  assign rel_err = rel_err_q;
  assign busy = busy_q;
  assign free_count = free_count_q;
  assign full = full_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_lab_pc_alloc_ctrl.sv
// tb_lab_pc_alloc_ctrl: scoreboard bench for lab_pc_alloc_ctrl (timeout test when LAB_PC_TIMEOUT_EN is defined)
module tb_lab_pc_alloc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic rel_valid = 1'b0;
  logic [2:0] rel_id = '0;
  logic req_ready, grant_valid, rel_err, full;
  logic [2:0] grant_id;
  logic [4:0] busy;
  logic [3:0] free_count;
  logic [6:0] seg;
`ifdef LAB_PC_TIMEOUT_EN
  logic timeout_valid;
  logic [2:0] timeout_id;
`endif
  int passed = 0;
  int total = 0;
  logic [2:0] exp_q[$];
  bit err_q[$];
  always #5 clk = ~clk;
  lab_pc_alloc_ctrl #(.N_PCS(5), .ID_W(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .grant_valid(grant_valid), .grant_id(grant_id), .rel_valid(rel_valid),
    .rel_id(rel_id), .rel_err(rel_err), .busy(busy), .free_count(free_count),
    .full(full), .seg(seg)
`ifdef LAB_PC_TIMEOUT_EN
    , .timeout_valid(timeout_valid), .timeout_id(timeout_id)
`endif
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string t, input int b, input int f, input int fl, input int sg, input int rdy);
    check({t, "_busy"}, int'(busy), b);
    check({t, "_free"}, int'(free_count), f);
    check({t, "_full"}, int'(full), fl);
    check({t, "_seg"}, int'(seg), sg);
    check({t, "_ready"}, int'(req_ready), rdy);
  endtask
  task automatic request(input logic [2:0] exp);
    bit ok = 1'b0;
    exp_q.push_back(exp);
    req_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = req_ready;
      tick();
    end
    req_valid = 1'b0;
    check("req_accept", int'(ok), 1);
  endtask
  task automatic release_pc(input logic [2:0] id, input bit err);
    if (err) err_q.push_back(1'b1);
    rel_valid = 1'b1;
    rel_id = id;
    tick();
    rel_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (grant_valid === 1'b1) begin
      if (exp_q.size() == 0) check("grant_unexpected", int'(grant_id), -1);
      else check("grant_id", int'(grant_id), int'(exp_q.pop_front()));
    end
    if (rel_err === 1'b1) begin
      if (err_q.size() == 0) check("rel_err_unexpected", int'(rel_err), 0);
      else begin
        void'(err_q.pop_front());
        check("rel_err", int'(rel_err), 1);
      end
    end
  end
  initial begin
    tick();
    tick();
    rst = 1'b0;
    st("reset", 5'b00000, 5, 0, 7'b1011011, 1);
    check("reset_grant_valid", int'(grant_valid), 0);
    check("reset_grant_id", int'(grant_id), 0);
    check("reset_rel_err", int'(rel_err), 0);
`ifdef LAB_PC_TIMEOUT_EN
    begin
      int hit = 0;
      int tid = -1;
      int b0 = -1;
      request(3'd0);
      for (int c = 1; c <= 12; c++) begin
        tick();
        if (timeout_valid && hit == 0) begin
          hit = c;
          tid = int'(timeout_id);
          b0 = int'(busy[0]);
        end
      end
      check("timeout_delay", hit, 8);
      check("timeout_id", tid, 0);
      check("timeout_busy0", b0, 0);
    end
`else
    for (int i = 0; i < 5; i++) request(3'(i));
    tick();
    st("full", 5'b11111, 0, 1, 7'b1111110, 0);
    release_pc(3'd2, 1'b0);
    st("rel2", 5'b11011, 1, 0, 7'b0110000, 1);
    request(3'd2);
    tick();
    st("regrant2", 5'b11111, 0, 1, 7'b1111110, 0);
    release_pc(3'd6, 1'b1);
    st("rel6", 5'b11111, 0, 1, 7'b1111110, 0);
    release_pc(3'd0, 1'b0);
    request(3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st("rst_grant", 5'b00000, 5, 0, 7'b1011011, 1);
    check("rst_grant_valid", int'(grant_valid), 0);
    request(3'd0);
    tick();
    exp_q.push_back(3'd1);
    check("same_cycle_ready", int'(req_ready), 1);
    rel_valid = 1'b1;
    rel_id = 3'd0;
    req_valid = 1'b1;
    tick();
    rel_valid = 1'b0;
    req_valid = 1'b0;
    tick();
    st("rel_and_req", 5'b00010, 4, 0, 7'b0110011, 1);
    release_pc(3'd0, 1'b1);
    st("rel_free", 5'b00010, 4, 0, 7'b0110011, 1);
    request(3'd2);
    release_pc(3'd2, 1'b1);
    st("rel_granting", 5'b00110, 3, 0, 7'b1111001, 1);
`endif
    tick();
    tick();
    check("grants_left", exp_q.size(), 0);
    check("rel_err_left", err_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
